// File: rtl/nms_window_top.sv
// nms_window_top: (2R+1)x(2R+1) non-maximum suppression over FAST scores
// with threshold, tie-break mode, frame resync and a per-frame keypoint cap.
module nms_window_top #(
  parameter int SCORE_WIDTH  = 8,
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480,
  parameter int NMS_RADIUS   = 1,
  parameter int TIE_MODE     = 0,
  parameter int MAX_KP       = 1024
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            sof,
  input  logic                            pixel_valid,
  input  logic                            is_corner_in,
  input  logic [SCORE_WIDTH-1:0]          score_in,
  input  logic [SCORE_WIDTH-1:0]          cfg_threshold,
  output logic                            nms_valid,
  output logic [SCORE_WIDTH-1:0]          nms_score,
  output logic [$clog2(IMAGE_WIDTH)-1:0]  nms_x,
  output logic [$clog2(IMAGE_HEIGHT)-1:0] nms_y,
  output logic [$clog2(MAX_KP+1)-1:0]     frame_kp_count,
  output logic                            kp_overflow
);

  localparam int R  = NMS_RADIUS;
  localparam int L  = 2 * R;
  localparam int N  = L + 1;
  localparam int SW = SCORE_WIDTH;
  localparam int EW = SW + 1;
  localparam int XW = $clog2(IMAGE_WIDTH);
  localparam int YW = $clog2(IMAGE_HEIGHT);
  localparam int CW = $clog2(MAX_KP + 1);

  if (NMS_RADIUS != 1 && NMS_RADIUS != 2) begin : g_bad_radius
    $error("NMS_RADIUS must be 1 or 2");
  end

  logic [XW-1:0] x_cnt;
  logic [XW-1:0] cur_x;
  logic [YW-1:0] y_cnt;
  logic [YW-1:0] cur_y;

  assign cur_x = sof ? '0 : x_cnt;
  assign cur_y = sof ? '0 : y_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (pixel_valid) begin
      if (cur_x == XW'(IMAGE_WIDTH - 1)) begin
        x_cnt <= '0;
        if (cur_y == YW'(IMAGE_HEIGHT - 1))
          y_cnt <= '0;
        else
          y_cnt <= cur_y + YW'(1);
      end else begin
        x_cnt <= cur_x + XW'(1);
        y_cnt <= cur_y;
      end
    end else if (sof) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end
  end

  // col[k] holds the pixel k rows above the incoming one, same column
  logic [EW-1:0] lb  [L][IMAGE_WIDTH];
  logic [EW-1:0] col [N];

  always_comb begin
    col[0] = {is_corner_in, score_in};
    for (int k = 1; k < N; k++)
      col[k] = lb[k-1][cur_x];
  end

  always_ff @(posedge clk) begin
    if (!rst && pixel_valid) begin
      for (int k = 0; k < L; k++)
        lb[k][cur_x] <= col[k];
    end
  end

  logic [EW-1:0] win [N][L];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < L; c++)
          win[r][c] <= '0;
    end else if (pixel_valid) begin
      for (int r = 0; r < N; r++) begin
        win[r][0] <= col[r];
        for (int c = 1; c < L; c++)
          win[r][c] <= win[r][c-1];
      end
    end
  end

  // ev[r][c] is pixel (cx+R-c, cy+R-r); column 0 is the live beat
  logic [EW-1:0] ev [N][N];

  always_comb begin
    for (int r = 0; r < N; r++) begin
      ev[r][0] = col[r];
      for (int c = 1; c < N; c++)
        ev[r][c] = win[r][c-1];
    end
  end

  logic [SW-1:0] ctr_sc;
  logic [SW-1:0] nb_sc;
  logic          ctr_corner;
  logic          earlier;
  logic          win_ok;

  always_comb begin
    ctr_sc     = ev[R][R][SW-1:0];
    ctr_corner = ev[R][R][SW];
    nb_sc      = '0;
    earlier    = 1'b0;
    win_ok     = 1'b1;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if (!(r == R && c == R)) begin
          nb_sc   = ev[r][c][SW] ? ev[r][c][SW-1:0] : '0;
          earlier = (r > R) || (r == R && c > R);
          if (TIE_MODE == 1 && earlier) begin
            if (ctr_sc < nb_sc)
              win_ok = 1'b0;
          end else if (ctr_sc <= nb_sc) begin
            win_ok = 1'b0;
          end
        end
      end
    end
  end

  // beat x,y >= 2R is the same as the center lying inside the border
  logic          in_border;
  logic          survivor;
  logic [XW-1:0] cx;
  logic [YW-1:0] cy;

  assign in_border = (cur_x >= XW'(L)) && (cur_y >= YW'(L));
  assign survivor  = pixel_valid && ctr_corner && win_ok && in_border &&
                     (ctr_sc >= cfg_threshold);
  assign cx        = cur_x - XW'(R);
  assign cy        = cur_y - YW'(R);

  always_ff @(posedge clk) begin
    if (rst) begin
      nms_valid      <= 1'b0;
      nms_score      <= '0;
      nms_x          <= '0;
      nms_y          <= '0;
      frame_kp_count <= '0;
      kp_overflow    <= 1'b0;
    end else begin
      nms_valid <= 1'b0;
      if (survivor) begin
        if (frame_kp_count < CW'(MAX_KP)) begin
          nms_valid      <= 1'b1;
          nms_score      <= ctr_sc;
          nms_x          <= cx;
          nms_y          <= cy;
          frame_kp_count <= frame_kp_count + CW'(1);
        end else begin
          kp_overflow <= 1'b1;
        end
      end
      if (sof) begin
        frame_kp_count <= '0;
        kp_overflow    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nms_window_top.sv
// tb_nms_window_top: four NMS configurations share one stimulus stream;
// a reference model fills a scoreboard that a monitor drains.
module tb_nms_window_top;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int NI = 4;
  localparam int RAD  [NI] = '{1, 1, 2, 1};
  localparam int TIE  [NI] = '{0, 1, 0, 0};
  localparam int MAXK [NI] = '{1024, 1024, 1024, 2};

  logic       clk = 1'b0;
  logic       rst;
  logic       sof;
  logic       pixel_valid;
  logic       is_corner_in;
  logic [7:0] score_in;
  logic [7:0] cfg_threshold;

  logic        ov [NI];
  logic [7:0]  os [NI];
  logic [2:0]  ox [NI];
  logic [2:0]  oy [NI];
  logic        oo [NI];
  logic [10:0] oc_a, oc_b, oc_c;
  logic [1:0]  oc_d;
  int          oc [NI];

  assign oc[0] = int'(oc_a);
  assign oc[1] = int'(oc_b);
  assign oc[2] = int'(oc_c);
  assign oc[3] = int'(oc_d);

  always #5 clk = ~clk;

  nms_window_top #(.SCORE_WIDTH(8), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H),
    .NMS_RADIUS(1), .TIE_MODE(0), .MAX_KP(1024)) u_a (
    .clk(clk), .rst(rst), .sof(sof), .pixel_valid(pixel_valid),
    .is_corner_in(is_corner_in), .score_in(score_in),
    .cfg_threshold(cfg_threshold), .nms_valid(ov[0]), .nms_score(os[0]),
    .nms_x(ox[0]), .nms_y(oy[0]), .frame_kp_count(oc_a),
    .kp_overflow(oo[0]));

  nms_window_top #(.SCORE_WIDTH(8), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H),
    .NMS_RADIUS(1), .TIE_MODE(1), .MAX_KP(1024)) u_b (
    .clk(clk), .rst(rst), .sof(sof), .pixel_valid(pixel_valid),
    .is_corner_in(is_corner_in), .score_in(score_in),
    .cfg_threshold(cfg_threshold), .nms_valid(ov[1]), .nms_score(os[1]),
    .nms_x(ox[1]), .nms_y(oy[1]), .frame_kp_count(oc_b),
    .kp_overflow(oo[1]));

  nms_window_top #(.SCORE_WIDTH(8), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H),
    .NMS_RADIUS(2), .TIE_MODE(0), .MAX_KP(1024)) u_c (
    .clk(clk), .rst(rst), .sof(sof), .pixel_valid(pixel_valid),
    .is_corner_in(is_corner_in), .score_in(score_in),
    .cfg_threshold(cfg_threshold), .nms_valid(ov[2]), .nms_score(os[2]),
    .nms_x(ox[2]), .nms_y(oy[2]), .frame_kp_count(oc_c),
    .kp_overflow(oo[2]));

  nms_window_top #(.SCORE_WIDTH(8), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H),
    .NMS_RADIUS(1), .TIE_MODE(0), .MAX_KP(2)) u_d (
    .clk(clk), .rst(rst), .sof(sof), .pixel_valid(pixel_valid),
    .is_corner_in(is_corner_in), .score_in(score_in),
    .cfg_threshold(cfg_threshold), .nms_valid(ov[3]), .nms_score(os[3]),
    .nms_x(ox[3]), .nms_y(oy[3]), .frame_kp_count(oc_d),
    .kp_overflow(oo[3]));

  typedef struct {
    int id;
    int sc;
    int x;
    int y;
    int cyc;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  bit fc [H][W];
  int fs [H][W];
  int mcnt [NI];
  bit movf [NI];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    int   k;
    exp_t e;
    #1;
    for (int i = 0; i < NI; i++) begin
      if (ov[i]) begin
        k = -1;
        for (int j = 0; j < sbq.size(); j++)
          if (sbq[j].id == i) begin
            k = j;
            break;
          end
        checks++;
        if (k < 0) begin
          errors++;
          $display("FAIL unexpected_kp inst=%0d got x=%0d y=%0d s=%0d required none",
                   i, ox[i], oy[i], os[i]);
        end else begin
          e = sbq[k];
          sbq.delete(k);
          if (int'(os[i]) != e.sc || int'(ox[i]) != e.x ||
              int'(oy[i]) != e.y || cyc != e.cyc + 1) begin
            errors++;
            $display("FAIL kp inst=%0d got x=%0d y=%0d s=%0d cyc=%0d required x=%0d y=%0d s=%0d cyc=%0d",
                     i, ox[i], oy[i], os[i], cyc, e.x, e.y, e.sc, e.cyc + 1);
          end
        end
      end
    end
  end

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_counts(string tag);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("%s_cnt%0d", tag, i), oc[i], mcnt[i]);
      chk($sformatf("%s_ovf%0d", tag, i), int'(oo[i]), int'(movf[i]));
    end
  endtask

  task automatic chk_zero(string tag);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("%s_valid%0d", tag, i), int'(ov[i]), 0);
      chk($sformatf("%s_score%0d", tag, i), int'(os[i]), 0);
      chk($sformatf("%s_x%0d", tag, i), int'(ox[i]), 0);
      chk($sformatf("%s_y%0d", tag, i), int'(oy[i]), 0);
      chk($sformatf("%s_cnt%0d", tag, i), oc[i], 0);
      chk($sformatf("%s_ovf%0d", tag, i), int'(oo[i]), 0);
    end
  endtask

  // Keypoint rule on the whole frame: strict max, or >= toward earlier pixels
  function automatic bit survive(int i, int cx, int cy, int thr);
    int r;
    int c0;
    int nb;
    bit early;
    r  = RAD[i];
    c0 = fs[cy][cx];
    if (!fc[cy][cx] || c0 < thr) return 1'b0;
    for (int dy = -r; dy <= r; dy++)
      for (int dx = -r; dx <= r; dx++) begin
        if (dy == 0 && dx == 0) continue;
        nb    = fc[cy+dy][cx+dx] ? fs[cy+dy][cx+dx] : 0;
        early = (dy < 0) || (dy == 0 && dx < 0);
        if (TIE[i] == 1 && early) begin
          if (c0 < nb) return 1'b0;
        end else if (c0 <= nb) begin
          return 1'b0;
        end
      end
    return 1'b1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NI; i++) begin
      mcnt[i] = 0;
      movf[i] = 1'b0;
    end
  endtask

  task automatic beat(int x, int y, bit s, int thr);
    int r, cx, cy;
    @(negedge clk);
    sof           = s;
    pixel_valid   = 1'b1;
    is_corner_in  = fc[y][x];
    score_in      = 8'(fs[y][x]);
    cfg_threshold = 8'(thr);
    if (s) model_clear();
    for (int i = 0; i < NI; i++) begin
      r  = RAD[i];
      cx = x - r;
      cy = y - r;
      if (cx >= r && cx <= W - 1 - r && cy >= r && cy <= H - 1 - r &&
          survive(i, cx, cy, thr)) begin
        if (mcnt[i] < MAXK[i]) begin
          sbq.push_back('{i, fs[cy][cx], cx, cy, cyc});
          mcnt[i]++;
        end else begin
          movf[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    sof           = 1'b0;
    pixel_valid   = 1'b0;
    is_corner_in  = 1'($urandom);
    score_in      = 8'($urandom);
    cfg_threshold = 8'($urandom);
  endtask

  task automatic run_frame(bit use_sof, int gap_pct, int thr_fix, int lim);
    int  n;
    int  thr;
    bit  done;
    n    = 0;
    done = 1'b0;
    for (int y = 0; y < H && !done; y++)
      for (int x = 0; x < W && !done; x++) begin
        if (lim >= 0 && n >= lim) begin
          done = 1'b1;
        end else begin
          while (int'($urandom_range(99)) < gap_pct) idle();
          thr = (thr_fix < 0) ? int'($urandom_range(7)) : thr_fix;
          beat(x, y, use_sof && x == 0 && y == 0, thr);
          n++;
        end
      end
    repeat (3) idle();
  endtask

  task automatic clear_frame();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        fc[y][x] = 1'b0;
        fs[y][x] = 0;
      end
  endtask

  task automatic set_px(int x, int y, int s);
    fc[y][x] = 1'b1;
    fs[y][x] = s;
  endtask

  task automatic rand_frame();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        fc[y][x] = ($urandom_range(99) < 40);
        fs[y][x] = int'($urandom_range(7));
      end
  endtask

  initial begin
    int thr;
    rst           = 1'b1;
    sof           = 1'b0;
    pixel_valid   = 1'b0;
    is_corner_in  = 1'b0;
    score_in      = '0;
    cfg_threshold = '0;
    model_clear();
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    clear_frame(); set_px(3, 2, 50);
    run_frame(1, 0, 10, -1);
    chk_counts("single");
    chk("single_cnt_r1", oc[0], 1);

    clear_frame(); set_px(3, 2, 50); set_px(4, 2, 50);
    run_frame(1, 0, 10, -1);
    chk_counts("plateau");

    clear_frame(); set_px(0, 0, 90); set_px(7, 3, 90); set_px(3, 5, 90);
    run_frame(1, 0, 10, -1);
    chk_counts("border");

    clear_frame(); set_px(1, 3, 80); set_px(2, 2, 90);
    run_frame(1, 0, 10, -1);
    chk_counts("r2border");

    clear_frame(); set_px(3, 2, 40);
    run_frame(1, 0, 41, -1);
    chk_counts("thr41");
    run_frame(1, 0, 40, -1);
    chk_counts("thr40");

    clear_frame();
    set_px(1, 1, 30); set_px(5, 1, 31); set_px(2, 4, 32); set_px(6, 4, 33);
    run_frame(1, 0, 10, -1);
    chk_counts("cap");
    chk("cap_cnt_d", oc[3], 2);
    chk("cap_ovf_d", int'(oo[3]), 1);

    @(negedge clk);
    sof = 1'b1;
    model_clear();
    idle();
    chk_counts("sof_clear");

    for (int f = 0; f < 3; f++) begin
      rand_frame();
      thr = int'($urandom_range(1, 5));
      run_frame(1, 0, thr, -1);
      chk_counts($sformatf("rand%0d_nogap", f));
      run_frame(1, 35, thr, -1);
      chk_counts($sformatf("rand%0d_gap", f));
    end

    rand_frame();
    run_frame(1, 25, -1, -1);
    chk_counts("rand_thr");

    rand_frame();
    run_frame(1, 10, 3, 20);
    rand_frame();
    run_frame(1, 10, 3, -1);
    chk_counts("resync");

    clear_frame(); set_px(3, 2, 50);
    run_frame(1, 0, 10, 36);
    chk("pre_rst_cnt", oc[0], 1);
    @(negedge clk);
    rst = 1'b1;
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    chk_zero("midrst");

    rand_frame();
    run_frame(0, 20, 2, -1);
    chk_counts("post_rst");

    repeat (3) idle();
    chk("leftover", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nms_window_top.md
Name: nms_window_top

Overview:
- Parametrised non-maximum suppression stage for FAST keypoints. Sits between the FAST score stage and the descriptor/keypoint packer.
- Generalises the fixed 3×3 NMS to a (2R+1)×(2R+1) window with R in {1,2}.
- Adds selectable tie-break, a runtime score threshold, explicit frame-start resync, and a per-frame keypoint cap with an overflow flag.
- The center corner flag travels with its score through the line storage, so flag and score are always aligned.

Parameters:
- SCORE_WIDTH, 8, score bit width.
- IMAGE_WIDTH, 640, pixels per row.
- IMAGE_HEIGHT, 480, rows per frame.
- NMS_RADIUS, 1, window radius R. Legal values are 1 or 2; any other value is an elaboration error.
- TIE_MODE, 0. 0 = strict: the center must be greater than all neighbours. 1 = raster tie-break: the center must be greater than or equal to neighbours earlier in raster order, and greater than later ones.
- MAX_KP, 1024, maximum keypoints emitted per frame.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- sof  in  1  start of frame. When high, the pixel on this beat (if pixel_valid) is (0,0).
- pixel_valid  in  1  score beat valid
- is_corner_in  in  1  FAST corner flag for the current pixel
- score_in  in  SCORE_WIDTH  FAST score for the current pixel
- cfg_threshold  in  SCORE_WIDTH  minimum center score. Sampled each beat.
- nms_valid  out  1  keypoint survives NMS (single-cycle pulse)
- nms_score  out  SCORE_WIDTH  surviving score
- nms_x  out  clog2(IMAGE_WIDTH)  keypoint column
- nms_y  out  clog2(IMAGE_HEIGHT)  keypoint row
- frame_kp_count  out  clog2(MAX_KP+1)  keypoints emitted this frame
- kp_overflow  out  1  sticky: at least one survivor was dropped due to the cap

Behaviour:
- Reset: all outputs are 0. x/y counters, window registers and kp count are 0. Line-buffer RAM contents are don't-care.
- Counters:
  - x increments per pixel_valid beat and wraps at IMAGE_WIDTH-1 with y+1.
  - y wraps to 0 after (IMAGE_WIDTH-1, IMAGE_HEIGHT-1).
  - sof forces x=y=0 for the beat it accompanies; with pixel_valid=0 it forces x=y=0 immediately.
  - sof also clears frame_kp_count and kp_overflow.
- Storage:
  - 2R line buffers of SCORE_WIDTH+1 bits, each entry {is_corner, score}.
  - A (2R+1)×(2R+1) register window shifts only on pixel_valid. Stall cycles hold all state.
- Window timing: the center at (cx,cy) is evaluated on the beat carrying pixel (cx+R, cy+R). That beat's x/y minus R gives the center coordinates, with modular arithmetic on x.
- Neighbour score: equals the stored score when its is_corner=1; a neighbour with is_corner=0 counts as score 0.
- Survivor condition, all of the following:
  - pixel_valid on the evaluation beat
  - center is_corner=1
  - center score >= cfg_threshold
  - window comparison passes per TIE_MODE
  - R <= cx <= IMAGE_WIDTH-1-R
  - R <= cy <= IMAGE_HEIGHT-1-R
- Border suppression is what makes row-wrap and stale line-buffer data at frame start harmless. No end-of-frame flush is needed.
- Output: registered, 1 cycle after the evaluation beat.
  - nms_valid is a 1-cycle pulse.
  - nms_score/x/y update only when nms_valid goes high, and hold otherwise.
- Cap:
  - While frame_kp_count < MAX_KP, each survivor emits and increments the count.
  - At MAX_KP, a survivor is suppressed (nms_valid stays 0) and kp_overflow is set.
  - The count saturates at MAX_KP.
- sof during a frame (mid-frame resync): window contents are not cleared. Border suppression guarantees no emission for the first R rows/cols of the new frame.
- sof on the same cycle as a survivor output: the survivor (belonging to the old frame) is still emitted. Count and overflow clear after it, so the emitted keypoint is not counted in the new frame.
- rst mid-frame: next cycle outputs are 0, counters are 0, and the next beat is treated as (0,0).
- Latency from the (cx+R, cy+R) input beat to nms_valid is 1 clk, excluding stall cycles.

Test Plan:
- R=1, W=8, H=6, TIE_MODE=0, all scores 0 except corner (3,2)=50, threshold 10 → exactly one pulse: x=3, y=2, score=50, 1 cycle after the beat for (4,3); frame_kp_count=1.
- Same setup, plateau: corners (3,2) and (4,2) both 50. TIE_MODE=0 → no output. TIE_MODE=1 → single keypoint at (4,2).
- Border: corners of score 90 at (0,0), (7,3) and (3,5), all other scores 0 → no nms_valid. R=2: corner at (1,3) suppressed, corner at (2,2) emitted.
- Threshold: center 40 at (3,2), cfg_threshold=41 → suppressed; cfg_threshold=40 → emitted.
- Cap: MAX_KP=2, four isolated corners → two outputs, frame_kp_count=2, kp_overflow=1. sof → both clear to 0.
- Stalls and reset:
  - Random pixel_valid gaps produce the same keypoints as a gapless stream.
  - rst asserted mid-row drives outputs to 0 next cycle; a following full frame yields the reference keypoints.
